// File: rtl/weight_loader_pkg.sv
// weight_loader_pkg: shared state encoding, default geometry and sizing helpers
package weight_loader_pkg;
  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_POF = 4;
  localparam int DEF_NKX = 3;
  localparam int DEF_NKY = 3;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    WR_HI = 2'd2,
    FIN   = 2'd3
  } state_t;
  function automatic int beats_of(input int total);
    return (total + 1) / 2;
  endfunction
  function automatic int width_of(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/weight_loader.sv
// weight_loader: unpacks two-weight beats into serial weight buffer writes and reports load status
module weight_loader
  import weight_loader_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int POF = DEF_POF,
  parameter int NKX = DEF_NKX,
  parameter int NKY = DEF_NKY,
  localparam int TOTAL = POF * NKX * NKY,
  localparam int BEATS = beats_of(TOTAL),
  localparam int WADDR_W = width_of(TOTAL),
  localparam int BEAT_W = width_of(BEATS) + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [2*DATA_WIDTH-1:0] s_data,
  input  logic                    s_last,
  output logic                    we,
  output logic [WADDR_W-1:0]      w_addr,
  output logic [DATA_WIDTH-1:0]   w_data,
  output logic                    busy,
  output logic                    done,
  output logic                    weights_valid,
  output logic                    err
);
  localparam bit ODD = (TOTAL % 2) == 1;
  state_t state, state_d;
  logic [WADDR_W-1:0] addr;
  logic [BEAT_W-1:0] beat;
  logic [DATA_WIDTH-1:0] hi_q;
  logic last_q;
  logic hs;
  logic beat_end;
  logic fin;
  assign hs = s_valid & s_ready;
  assign beat_end = beat == BEAT_W'(BEATS - 1);
  assign fin = beat_end | s_last;
  // state register
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_d;
  // next state: an odd-sized set skips the high write of its last counted beat
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    state_d = start ? RECV : IDLE;
      RECV:    state_d = hs ? ((ODD && beat_end) ? FIN : WR_HI) : RECV;
      WR_HI:   state_d = last_q ? FIN : RECV;
      default: state_d = IDLE;
    endcase
  end
  // handshake and status outputs; busy covers the done cycle so it falls one cycle after done
  always_comb begin
    s_ready = state == RECV;
    busy = (state != IDLE) | done;
  end
  // capture beats, emit the two registered buffer writes and track load status
  always_ff @(posedge clk)
    if (rst) begin
      we <= 1'b0;
      w_addr <= '0;
      w_data <= '0;
      hi_q <= '0;
      addr <= '0;
      beat <= '0;
      last_q <= 1'b0;
      done <= 1'b0;
      weights_valid <= 1'b0;
      err <= 1'b0;
    end else begin
      we <= 1'b0;
      done <= state == FIN;
      if (state == IDLE && start) begin
        addr <= '0;
        beat <= '0;
        err <= 1'b0;
        weights_valid <= 1'b0;
      end
      if (hs) begin
        we <= 1'b1;
        w_addr <= addr;
        w_data <= s_data[DATA_WIDTH-1:0];
        hi_q <= s_data[2*DATA_WIDTH-1:DATA_WIDTH];
        addr <= addr + WADDR_W'(1);
        beat <= beat + BEAT_W'(1);
        last_q <= fin;
        err <= err | (s_last ^ beat_end);
      end
      if (state == WR_HI) begin
        we <= 1'b1;
        w_addr <= addr;
        w_data <= hi_q;
        addr <= addr + WADDR_W'(1);
      end
      if (state == FIN) weights_valid <= ~err;
    end
endmodule

// File: tb/tb_weight_loader.sv
// tb_weight_loader: directed checks of the weight loader with a behavioural weight buffer
module tb_weight_loader;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic s_valid = 1'b0;
  logic s_last = 1'b0;
  logic [31:0] s_data = '0;
  logic s_ready, we, busy, done, weights_valid, err;
  logic [5:0] w_addr;
  logic [15:0] w_data;
  logic o_start = 1'b0;
  logic o_valid = 1'b0;
  logic o_last = 1'b0;
  logic [31:0] o_data = '0;
  logic o_ready, o_we, o_busy, o_done, o_wv, o_err;
  logic [3:0] o_addr;
  logic [15:0] o_wdata;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int hs_cnt = 0;
  int rdy_viol = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  bit hs_prev = 1'b0;
  logic [15:0] mem [36];
  logic [15:0] omem [9];
  int wa[$], wd[$], wc[$], owa[$], owd[$];

  weight_loader u_dut (
    .clk(clk), .rst(rst), .start(start), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_last(s_last), .we(we), .w_addr(w_addr), .w_data(w_data),
    .busy(busy), .done(done), .weights_valid(weights_valid), .err(err)
  );

  weight_loader #(.POF(1)) u_odd (
    .clk(clk), .rst(rst), .start(o_start), .s_valid(o_valid), .s_ready(o_ready),
    .s_data(o_data), .s_last(o_last), .we(o_we), .w_addr(o_addr), .w_data(o_wdata),
    .busy(o_busy), .done(o_done), .weights_valid(o_wv), .err(o_err)
  );

  always #5 clk = ~clk;

  // buffer model and stream observers, sampled mid-cycle
  always @(negedge clk) begin
    cyc++;
    if (s_ready && hs_prev) rdy_viol++;
    hs_prev = s_valid && s_ready;
    if (hs_prev) hs_cnt++;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (rst) begin
      foreach (mem[i]) mem[i] = '0;
      foreach (omem[i]) omem[i] = '0;
    end else begin
      if (we) begin
        if (w_addr < 6'd36) mem[w_addr] = w_data;
        wa.push_back(int'(w_addr));
        wd.push_back(int'(w_data));
        wc.push_back(cyc);
      end
      if (o_we) begin
        if (o_addr < 4'd9) omem[o_addr] = o_wdata;
        owa.push_back(int'(o_addr));
        owd.push_back(int'(o_wdata));
      end
    end
  end

  task automatic do_rst;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic pulse_start(input bit sel);
    @(posedge clk); #1;
    if (sel) o_start = 1'b1;
    else start = 1'b1;
    @(posedge clk); #1;
    o_start = 1'b0;
    start = 1'b0;
  endtask

  task automatic stream(input bit sel, input int n, input int last_at, input int base,
                        input bit bp, input int start_at, output int acc);
    int c;
    bit v;
    c = 0;
    acc = 0;
    while (acc < n && c < 400) begin
      v = bp ? ($urandom_range(0, 1) == 1) : 1'b1;
      if (sel) begin
        o_valid = v;
        o_data = {16'(base + 2 * acc + 1), 16'(base + 2 * acc)};
        o_last = acc == last_at;
      end else begin
        s_valid = v;
        s_data = {16'(base + 2 * acc + 1), 16'(base + 2 * acc)};
        s_last = acc == last_at;
        start = c == start_at;
      end
      if (v && (sel ? o_ready : s_ready)) acc++;
      c++;
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    s_last = 1'b0;
    o_valid = 1'b0;
    o_last = 1'b0;
    start = 1'b0;
  endtask

  task automatic wait_done(input bit sel, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok = sel ? o_done : done;
    end
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({s_ready, we, w_addr, w_data, busy, done, weights_valid, err} !== 30'd0) begin
      bad++;
      $display("FAIL reset_outputs got=%0h want=0", {s_ready, we, w_addr, w_data, busy, done, weights_valid, err});
    end
    total++;
    if ({o_ready, o_we, o_addr, o_wdata, o_busy, o_done, o_wv, o_err} !== 28'd0) begin
      bad++;
      $display("FAIL reset_odd_outputs got=%0h want=0", {o_ready, o_we, o_addr, o_wdata, o_busy, o_done, o_wv, o_err});
    end
    rst = 1'b0;
  endtask

  task automatic test_nominal;
    int n0, v0, acc;
    bit ok;
    n0 = wa.size();
    v0 = rdy_viol;
    pulse_start(0);
    total++;
    if ({s_ready, busy} !== 2'b11) begin
      bad++;
      $display("FAIL nom_start_ready got=%0b want=11", {s_ready, busy});
    end
    stream(0, 18, 17, 0, 0, -1, acc);
    total++;
    if (acc !== 18) begin
      bad++;
      $display("FAIL nom_beats got=%0d want=18", acc);
    end
    wait_done(0, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL nom_done_seen got=0 want=1");
    end
    total++;
    if ({weights_valid, err, busy} !== 3'b101) begin
      bad++;
      $display("FAIL nom_flags got=%0b want=101", {weights_valid, err, busy});
    end
    @(negedge clk);
    total++;
    if ({busy, done} !== 2'b00) begin
      bad++;
      $display("FAIL nom_busy_end got=%0b want=00", {busy, done});
    end
    total++;
    if (wa.size() - n0 !== 36) begin
      bad++;
      $display("FAIL nom_wcount got=%0d want=36", wa.size() - n0);
    end else begin
      total++;
      if (wc[n0 + 35] - wc[n0] !== 35) begin
        bad++;
        $display("FAIL nom_we_span got=%0d want=35", wc[n0 + 35] - wc[n0]);
      end
      total++;
      if (done_cyc - wc[n0] !== 36) begin
        bad++;
        $display("FAIL nom_done_latency got=%0d want=36", done_cyc - wc[n0]);
      end
      for (int i = 0; i < 36; i++) begin
        total++;
        if (wa[n0 + i] !== i || wd[n0 + i] !== i) begin
          bad++;
          $display("FAIL nom_write[%0d] got=%0d/%0d want=%0d/%0d", i, wa[n0 + i], wd[n0 + i], i, i);
        end
      end
    end
    for (int i = 0; i < 36; i++) begin
      total++;
      if (mem[i] !== 16'(i)) begin
        bad++;
        $display("FAIL nom_mem[%0d] got=%0d want=%0d", i, mem[i], i);
      end
    end
    total++;
    if (rdy_viol !== v0) begin
      bad++;
      $display("FAIL nom_ready_in_wr_hi got=%0d want=%0d", rdy_viol, v0);
    end
  endtask

  task automatic test_backpressure;
    int n0, v0, acc;
    bit ok;
    do_rst();
    n0 = wa.size();
    v0 = rdy_viol;
    pulse_start(0);
    stream(0, 18, 17, 0, 1, -1, acc);
    total++;
    if (acc !== 18) begin
      bad++;
      $display("FAIL bp_beats got=%0d want=18", acc);
    end
    wait_done(0, ok);
    total++;
    if (!ok || {weights_valid, err} !== 2'b10) begin
      bad++;
      $display("FAIL bp_flags got=%0b want=110", {ok, weights_valid, err});
    end
    @(negedge clk);
    total++;
    if (wa.size() - n0 !== 36) begin
      bad++;
      $display("FAIL bp_wcount got=%0d want=36", wa.size() - n0);
    end else begin
      for (int i = 0; i < 36; i++) begin
        total++;
        if (wa[n0 + i] !== i || wd[n0 + i] !== i) begin
          bad++;
          $display("FAIL bp_write[%0d] got=%0d/%0d want=%0d/%0d", i, wa[n0 + i], wd[n0 + i], i, i);
        end
      end
    end
    total++;
    if (rdy_viol !== v0) begin
      bad++;
      $display("FAIL bp_ready_in_wr_hi got=%0d want=%0d", rdy_viol, v0);
    end
  endtask

  task automatic test_early_last;
    int n0, acc, nz;
    bit ok;
    do_rst();
    n0 = wa.size();
    pulse_start(0);
    stream(0, 6, 5, 0, 0, -1, acc);
    wait_done(0, ok);
    total++;
    if (!ok || {weights_valid, err} !== 2'b01) begin
      bad++;
      $display("FAIL early_flags got=%0b want=101", {ok, weights_valid, err});
    end
    @(negedge clk);
    total++;
    if (wa.size() - n0 !== 12) begin
      bad++;
      $display("FAIL early_wcount got=%0d want=12", wa.size() - n0);
    end else begin
      for (int i = 0; i < 12; i++) begin
        total++;
        if (wa[n0 + i] !== i || wd[n0 + i] !== i) begin
          bad++;
          $display("FAIL early_write[%0d] got=%0d/%0d want=%0d/%0d", i, wa[n0 + i], wd[n0 + i], i, i);
        end
      end
    end
    nz = 0;
    for (int i = 12; i < 36; i++) if (mem[i] !== 16'd0) nz++;
    total++;
    if (nz !== 0) begin
      bad++;
      $display("FAIL early_untouched got=%0d want=0", nz);
    end
  endtask

  task automatic test_missing_last;
    int n0, h0, acc;
    bit ok;
    do_rst();
    n0 = wa.size();
    pulse_start(0);
    stream(0, 18, -1, 0, 0, -1, acc);
    h0 = hs_cnt;
    s_valid = 1'b1;
    wait_done(0, ok);
    total++;
    if (!ok || {weights_valid, err} !== 2'b01) begin
      bad++;
      $display("FAIL miss_flags got=%0b want=101", {ok, weights_valid, err});
    end
    repeat (5) @(negedge clk);
    total++;
    if (hs_cnt !== h0) begin
      bad++;
      $display("FAIL miss_extra_beats got=%0d want=%0d", hs_cnt, h0);
    end
    s_valid = 1'b0;
    total++;
    if (wa.size() - n0 !== 36) begin
      bad++;
      $display("FAIL miss_wcount got=%0d want=36", wa.size() - n0);
    end
  endtask

  task automatic test_start_midload;
    int n0, d0, acc;
    bit ok;
    do_rst();
    n0 = wa.size();
    d0 = done_cnt;
    pulse_start(0);
    stream(0, 18, 17, 0, 0, 8, acc);
    wait_done(0, ok);
    total++;
    if (!ok || {weights_valid, err} !== 2'b10) begin
      bad++;
      $display("FAIL mid_flags got=%0b want=110", {ok, weights_valid, err});
    end
    repeat (3) @(negedge clk);
    total++;
    if (done_cnt - d0 !== 1 || wa.size() - n0 !== 36) begin
      bad++;
      $display("FAIL mid_counts got=%0d/%0d want=1/36", done_cnt - d0, wa.size() - n0);
    end
    for (int i = 0; i < 36; i++) begin
      total++;
      if (mem[i] !== 16'(i)) begin
        bad++;
        $display("FAIL mid_mem[%0d] got=%0d want=%0d", i, mem[i], i);
      end
    end
  endtask

  task automatic test_restart;
    int acc;
    bit ok;
    @(posedge clk); #1;
    start = 1'b1;
    total++;
    if (weights_valid !== 1'b1) begin
      bad++;
      $display("FAIL restart_wv_before got=%0b want=1", weights_valid);
    end
    @(posedge clk); #1;
    start = 1'b0;
    total++;
    if ({weights_valid, s_ready} !== 2'b01) begin
      bad++;
      $display("FAIL restart_wv_drop got=%0b want=01", {weights_valid, s_ready});
    end
    stream(0, 18, 17, 100, 0, -1, acc);
    wait_done(0, ok);
    total++;
    if (!ok || {weights_valid, err} !== 2'b10) begin
      bad++;
      $display("FAIL restart_flags got=%0b want=110", {ok, weights_valid, err});
    end
    @(negedge clk);
    for (int i = 0; i < 36; i++) begin
      total++;
      if (mem[i] !== 16'(100 + i)) begin
        bad++;
        $display("FAIL restart_mem[%0d] got=%0d want=%0d", i, mem[i], 100 + i);
      end
    end
  endtask

  task automatic test_rst_midload;
    int n0, acc;
    bit ok;
    pulse_start(0);
    stream(0, 10, -1, 0, 0, -1, acc);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    total++;
    if ({s_ready, we, w_addr, w_data, busy, done, weights_valid, err} !== 30'd0) begin
      bad++;
      $display("FAIL rst_mid_outputs got=%0h want=0", {s_ready, we, w_addr, w_data, busy, done, weights_valid, err});
    end
    n0 = wa.size();
    pulse_start(0);
    stream(0, 18, 17, 0, 0, -1, acc);
    wait_done(0, ok);
    total++;
    if (!ok || {weights_valid, err} !== 2'b10) begin
      bad++;
      $display("FAIL rst_mid_reload got=%0b want=110", {ok, weights_valid, err});
    end
    @(negedge clk);
    total++;
    if (wa.size() - n0 !== 36) begin
      bad++;
      $display("FAIL rst_mid_wcount got=%0d want=36", wa.size() - n0);
    end else begin
      for (int i = 0; i < 36; i++) begin
        total++;
        if (wa[n0 + i] !== i || wd[n0 + i] !== i) begin
          bad++;
          $display("FAIL rst_mid_write[%0d] got=%0d/%0d want=%0d/%0d", i, wa[n0 + i], wd[n0 + i], i, i);
        end
      end
    end
  endtask

  task automatic test_odd;
    int n0, acc, mx;
    bit ok;
    n0 = owa.size();
    pulse_start(1);
    total++;
    if (o_ready !== 1'b1) begin
      bad++;
      $display("FAIL odd_start_ready got=%0b want=1", o_ready);
    end
    stream(1, 5, 4, 0, 0, -1, acc);
    wait_done(1, ok);
    total++;
    if (!ok || {o_wv, o_err} !== 2'b10) begin
      bad++;
      $display("FAIL odd_flags got=%0b want=110", {ok, o_wv, o_err});
    end
    @(negedge clk);
    total++;
    if (owa.size() - n0 !== 9) begin
      bad++;
      $display("FAIL odd_wcount got=%0d want=9", owa.size() - n0);
    end else begin
      mx = 0;
      for (int i = 0; i < 9; i++) begin
        if (owa[n0 + i] > mx) mx = owa[n0 + i];
        total++;
        if (owa[n0 + i] !== i || owd[n0 + i] !== i) begin
          bad++;
          $display("FAIL odd_write[%0d] got=%0d/%0d want=%0d/%0d", i, owa[n0 + i], owd[n0 + i], i, i);
        end
      end
      total++;
      if (mx !== 8) begin
        bad++;
        $display("FAIL odd_max_addr got=%0d want=8", mx);
      end
    end
    for (int i = 0; i < 9; i++) begin
      total++;
      if (omem[i] !== 16'(i)) begin
        bad++;
        $display("FAIL odd_mem[%0d] got=%0d want=%0d", i, omem[i], i);
      end
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_backpressure();
    test_early_last();
    test_missing_last();
    test_start_midload();
    test_restart();
    test_rst_midload();
    test_odd();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
